// File: rtl/mem_arbiter.sv
// mem_arbiter: Wishbone/CPU arbiter for a 4-bank shared memory; MEM_ARB_RR_EN enables round-robin on simultaneous requests.
module mem_arbiter #(
  parameter logic [15:0] WB_BASE = 16'h3000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        cpu_en,
  input  logic        cpu_rw,
  input  logic [11:0] addr_from_cpu,
  input  logic [15:0] data_from_cpu,
  output logic        cpu_rdy,
  output logic [15:0] data_to_cpu,
  output logic [3:0]  en_to_memB,
  output logic        rw_to_mem,
  output logic [8:0]  addr_to_mem,
  output logic [15:0] data_to_mem,
  input  logic [15:0] data_from_mem0,
  input  logic [15:0] data_from_mem1,
  input  logic [15:0] data_from_mem2,
  input  logic [15:0] data_from_mem3
);
  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, we_q, we_d, bad_q, bad_d;
  logic [1:0] bank_q, bank_d;
  logic [8:0] word_q, word_d;
  logic [15:0] wdat_q, wdat_d, rdat_q, rdat_d, mem_rd;
  logic hit, wb_req, grant_wb, go, done, unused;
  assign unused = ^{wbs_adr_i[15:13], wbs_adr_i[1:0], wbs_dat_i[31:16], addr_from_cpu[11]};
  assign hit = wbs_adr_i[31:16] == WB_BASE;
  assign wb_req = wbs_cyc_i & wbs_stb_i & hit;
`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;
  assign grant_wb = wb_req & (~cpu_en | ~last_q);
  assign last_d = go ? grant_wb : last_q;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) last_q <= 1'b0;
    else last_q <= last_d;
`else
  assign grant_wb = wb_req & ~cpu_en;
`endif
  assign go = (state_q == IDLE) & (cpu_en | wb_req);
  assign done = state_q == COMPLETE;
  always_comb begin
    state_d = go ? ACCESS : (state_q == ACCESS) ? COMPLETE : IDLE;
    owner_d = go ? grant_wb : owner_q;
    bank_d = go ? (grant_wb ? wbs_adr_i[12:11] : addr_from_cpu[10:9]) : bank_q;
    word_d = go ? (grant_wb ? wbs_adr_i[10:2] : addr_from_cpu[8:0]) : word_q;
    we_d = go ? (grant_wb ? wbs_we_i : cpu_rw) : we_q;
    wdat_d = go ? (grant_wb ? wbs_dat_i[15:0] : data_from_cpu) : wdat_q;
    mem_rd = bank_q[1] ? (bank_q[0] ? data_from_mem3 : data_from_mem2)
                       : (bank_q[0] ? data_from_mem1 : data_from_mem0);
    rdat_d = (done & ~owner_q & ~we_q) ? mem_rd : rdat_q;
    // off-base cycles get a one-shot ack without involving the FSM
    bad_d = wbs_cyc_i & wbs_stb_i & ~hit & ~bad_q;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q <= 1'b0;
      bad_q <= 1'b0;
      bank_q <= 2'd0;
      word_q <= 9'd0;
      wdat_q <= 16'd0;
      rdat_q <= 16'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q <= we_d;
      bad_q <= bad_d;
      bank_q <= bank_d;
      word_q <= word_d;
      wdat_q <= wdat_d;
      rdat_q <= rdat_d;
    end
  assign en_to_memB = (state_q == ACCESS) ? ~(4'b0001 << bank_q) : 4'hF;
  assign rw_to_mem = we_q;
  assign addr_to_mem = word_q;
  assign data_to_mem = wdat_q;
  assign wbs_ack_o = (done & owner_q) | bad_q;
  assign wbs_dat_o = {16'h0, (done & owner_q & ~we_q) ? mem_rd : 16'h0};
  assign cpu_rdy = done & ~owner_q;
  assign data_to_cpu = rdat_q;
endmodule
